// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one shared ALU, one req/ready memory port,
// internal 32x32 register file, and an absorbing TRAP state.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              retire,
  output logic              trap,
  output logic [31:0]       pc_dbg,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, ir, a, b, alu_out, mdr;
  logic [31:0] rf [32];
  logic        retire_d;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, alu_y, addr_full;
  logic        is_r, is_lw, is_sw, is_beq, is_addi, is_j, funct_ok, legal, is_mem;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};

  assign is_r    = (op == 6'h00);
  assign is_lw   = (op == 6'h23);
  assign is_sw   = (op == 6'h2B);
  assign is_beq  = (op == 6'h04);
  assign is_addi = (op == 6'h08);
  assign is_j    = (op == 6'h02);
  assign is_mem  = is_lw | is_sw;

  always_comb begin
    funct_ok = 1'b0;
    case (funct)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: funct_ok = 1'b1;
      default:                           funct_ok = 1'b0;
    endcase
  end

  assign legal = (is_r & funct_ok) | is_lw | is_sw | is_beq | is_addi | is_j;

  // Shared ALU: branch target in DECODE, operation/effective address in EXEC.
  always_comb begin
    alu_y = 32'h0;
    case (state)
      S_DECODE: alu_y = pc + {imm_sext[29:0], 2'b00};
      S_EXEC: begin
        if (is_r) begin
          case (funct)
            6'h20:   alu_y = a + b;
            6'h22:   alu_y = a - b;
            6'h24:   alu_y = a & b;
            6'h25:   alu_y = a | b;
            6'h2A:   alu_y = {31'h0, $signed(a) < $signed(b)};
            default: alu_y = 32'h0;
          endcase
        end else begin
          alu_y = a + imm_sext;
        end
      end
      default: alu_y = 32'h0;
    endcase
  end

  // Handshake: an access is offered while mem_req=1 with addr/we/wdata held
  // stable; it completes on the rising edge where mem_ready is also 1.
  assign addr_full = (state == S_MEM) ? alu_out : pc;
  assign mem_addr  = addr_full[ADDR_W-1:0];
  assign mem_req   = !Rst && ((state == S_FETCH) || (state == S_MEM));
  assign mem_we    = (state == S_MEM) && is_sw;
  assign mem_wdata = b;
  assign trap      = (state == S_TRAP);
  assign pc_dbg    = pc;
  assign state_dbg = state;

  always_comb begin
    state_next = state;
    retire_d   = 1'b0;
    case (state)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_beq || is_j) begin
          state_next = S_FETCH;
          retire_d   = 1'b1;
        end else if (is_mem && (alu_y[1:0] != 2'b00)) begin
          state_next = S_TRAP;
        end else if (is_mem) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_sw) begin
            state_next = S_FETCH;
            retire_d   = 1'b1;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        state_next = S_FETCH;
        retire_d   = 1'b1;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc      <= RESET_PC;
      ir      <= 32'h0;
      a       <= 32'h0;
      b       <= 32'h0;
      alu_out <= 32'h0;
      mdr     <= 32'h0;
      retire  <= 1'b0;
    end else begin
      retire <= retire_d;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a       <= rf[rs];
          b       <= rf[rt];
          alu_out <= alu_y;
        end
        S_EXEC: begin
          if (is_beq) begin
            if (a == b) pc <= alu_out;
          end else if (is_j) begin
            pc <= {pc[31:28], ir[25:0], 2'b00};
          end else begin
            alu_out <= alu_y;
          end
        end
        S_MEM:   if (mem_ready && !is_sw) mdr <= mem_rdata;
        default: ;
      endcase
    end
  end

  always_comb begin
    rf_we    = (state == S_WB);
    rf_waddr = is_r ? rd : rt;
    rf_wdata = is_lw ? mdr : alu_out;
  end

  // r0 is never written, so it keeps reading as zero.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: directed cases plus random programs checked
// against an instruction-level model with a store scoreboard.
module tb_mips_multicycle_core;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        mem_req, mem_we, mem_ready, retire, trap;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
  logic [2:0]  state_dbg;

  mips_multicycle_core #(.RESET_PC(RPC), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst(Rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .retire(retire), .trap(trap), .pc_dbg(pc_dbg), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- memory responder ----------------
  logic [31:0] mem [1024];
  int          wait_f = 0, wait_d = 0, cnt, wait_sel;
  bit          stall_en = 1'b0;
  logic [31:0] stall_addr = 32'h40;

  assign wait_sel  = (mem_addr >= 32'h100 && mem_addr < 32'h800) ? wait_f : wait_d;
  assign mem_ready = mem_req && (cnt >= wait_sel) && !(stall_en && mem_addr == stall_addr);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge Clk or posedge Rst) begin
    if (Rst)                       cnt <= 0;
    else if (mem_req && !mem_ready) cnt <= cnt + 1;
    else                           cnt <= 0;
  end

  // ---------------- scoreboard / checking ----------------
  logic [63:0] exp_q[$];
  int          n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int f, input int rd, input int rs, input int rt);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], 5'h00, f[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rt, input int rs, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    return {6'h02, tgt[25:0]};
  endfunction

  // ---------------- reference model (instruction level) ----------------
  task automatic model_run(input int n, input int wf, input int wd, output int m_ret,
                           output bit m_trap, output int m_cyc, output logic [31:0] m_pc);
    logic [31:0] m_rf [32];
    logic [31:0] dm [1024];
    logic [31:0] pc, ins, npc, simm, ea, x, y, r;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    for (int i = 0; i < 1024; i++) dm[i] = mem[i];
    pc = RPC; m_ret = 0; m_trap = 1'b0; m_cyc = 0;
    while (m_ret < n && !m_trap) begin
      ins  = dm[pc[11:2]];
      npc  = pc + 32'd4;
      simm = {{16{ins[15]}}, ins[15:0]};
      x    = m_rf[ins[25:21]];
      y    = m_rf[ins[20:16]];
      r    = 32'h0;
      ea   = x + simm;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'h20:   r = x + y;
            6'h22:   r = x - y;
            6'h24:   r = x & y;
            6'h25:   r = x | y;
            6'h2A:   r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: m_trap = 1'b1;
          endcase
          if (m_trap) m_cyc += 2 + wf;
          else begin
            if (ins[15:11] != 5'd0) m_rf[ins[15:11]] = r;
            m_cyc += 4 + wf;
          end
        end
        6'h08: begin
          if (ins[20:16] != 5'd0) m_rf[ins[20:16]] = x + simm;
          m_cyc += 4 + wf;
        end
        6'h23: begin
          if (ea[1:0] != 2'b00) begin m_trap = 1'b1; m_cyc += 3 + wf; end
          else begin
            if (ins[20:16] != 5'd0) m_rf[ins[20:16]] = dm[ea[11:2]];
            m_cyc += 5 + wf + wd;
          end
        end
        6'h2B: begin
          if (ea[1:0] != 2'b00) begin m_trap = 1'b1; m_cyc += 3 + wf; end
          else begin
            dm[ea[11:2]] = y;
            exp_q.push_back({ea, y});
            m_cyc += 4 + wf + wd;
          end
        end
        6'h04: begin
          if (x == y) npc = npc + (simm << 2);
          m_cyc += 3 + wf;
        end
        6'h02: begin
          npc = {npc[31:28], ins[25:0], 2'b00};
          m_cyc += 3 + wf;
        end
        default: begin m_trap = 1'b1; m_cyc += 2 + wf; end
      endcase
      pc = npc;
      if (!m_trap) m_ret++;
    end
    m_pc = pc;
  endtask

  // ---------------- driver ----------------
  logic [31:0] ret_pc[$];
  int          ret_cyc[$];
  int          trap_cyc;
  logic        first_req, last_trap;
  logic [31:0] first_addr, last_pc;
  bit          stab_en = 1'b0;

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
  endtask

  task automatic sb_store();
    logic [63:0] e;
    mem[mem_addr[11:2]] = mem_wdata;
    if (exp_q.size() == 0) check("store_unexpected", {mem_addr, mem_wdata}, 64'h0);
    else begin
      e = exp_q.pop_front();
      check("store", {mem_addr, mem_wdata}, e);
    end
  endtask

  // Resets, releases, then runs until n retires, a trap, or the budget.
  task automatic run_dut(input int n, input int budget, input bit hold);
    int          c;
    bit          pend;
    logic [33:0] saved_ctl;
    logic [31:0] saved_wd;
    Rst = 1'b1;
    ret_pc.delete(); ret_cyc.delete(); trap_cyc = -1; pend = 1'b0;
    saved_ctl = '0; saved_wd = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    #1 first_req = mem_req; first_addr = mem_addr;
    c = 0;
    while (ret_pc.size() < n && trap_cyc < 0 && c < budget) begin
      @(negedge Clk);
      if (stab_en && pend) begin
        check("hold_ctl", {mem_req, mem_we, mem_addr}, saved_ctl);
        check("hold_wdata", mem_wdata, saved_wd);
      end
      pend      = mem_req && !mem_ready;
      saved_ctl = {mem_req, mem_we, mem_addr};
      saved_wd  = mem_wdata;
      if (mem_req && mem_ready && mem_we) sb_store();
      @(posedge Clk);
      #1 c++;
      if (retire) begin ret_pc.push_back(pc_dbg); ret_cyc.push_back(c); end
      if (trap && trap_cyc < 0) trap_cyc = c;
    end
    check("run_timeout", (ret_pc.size() < n && trap_cyc < 0), 0);
    last_pc = pc_dbg; last_trap = trap;
    if (!hold) Rst = 1'b1;
  endtask

  // ---------------- main ----------------
  initial begin
    int          m_ret, m_cyc, bad, c, last;
    bit          m_trap;
    logic [31:0] m_pc;
    int          k, sel;

    // Reset values
    clear_mem();
    repeat (3) @(negedge Clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, RPC);
    check("rst_wdata", mem_wdata, 0);
    check("rst_retire", retire, 0);
    check("rst_trap", trap, 0);
    check("rst_pc", pc_dbg, RPC);

    // addi/addi/add/sw, zero-wait
    mem[64] = enc_i(8, 1, 0, 5);
    mem[65] = enc_i(8, 2, 0, 7);
    mem[66] = enc_r(32'h20, 3, 1, 2);
    mem[67] = enc_i(32'h2B, 3, 0, 32'h40);
    exp_q.push_back({32'h40, 32'd12});
    run_dut(4, 100, 1'b0);
    check("first_req", first_req, 1);
    check("first_addr", first_addr, RPC);
    check("seq_retires", ret_pc.size(), 4);
    check("seq_cycles", (ret_cyc.size() == 4) ? ret_cyc[3] : -1, 16);
    check("seq_drain", exp_q.size(), 0);
    check("seq_trap", last_trap, 0);

    // lw with 3 data wait states
    mem[64] = enc_i(32'h23, 4, 0, 32'h40);
    mem[65] = enc_i(32'h2B, 4, 0, 32'h44);
    mem[66] = 32'h0;
    mem[67] = 32'h0;
    exp_q.push_back({32'h44, 32'd12});
    wait_d = 3; stab_en = 1'b1;
    run_dut(2, 100, 1'b0);
    check("lw_cycles", (ret_cyc.size() > 0) ? ret_cyc[0] : -1, 8);
    check("lw_drain", exp_q.size(), 0);
    wait_d = 0; stab_en = 1'b0;

    // slt signed, beq taken, j
    clear_mem();
    mem[64]  = enc_i(8, 1, 0, 32'hFFFF);
    mem[65]  = enc_i(8, 2, 0, 1);
    mem[66]  = enc_r(32'h2A, 3, 1, 2);
    mem[67]  = enc_i(32'h2B, 3, 0, 32'h50);
    mem[68]  = enc_j(32'h80);
    mem[128] = enc_i(4, 1, 1, 2);
    mem[131] = enc_j(32'h40);
    exp_q.push_back({32'h50, 32'd1});
    run_dut(7, 200, 1'b0);
    check("slt_drain", exp_q.size(), 0);
    check("j_to_200", (ret_pc.size() == 7) ? ret_pc[4] : 32'h0, 32'h200);
    check("beq_target", (ret_pc.size() == 7) ? ret_pc[5] : 32'h0, 32'h20C);
    check("j_target", (ret_pc.size() == 7) ? ret_pc[6] : 32'h0, 32'h100);
    check("beq_cycles", (ret_cyc.size() == 7) ? ret_cyc[5] - ret_cyc[4] : -1, 3);

    // Illegal opcode traps and holds
    clear_mem();
    mem[64] = 32'hFC00_0000;
    run_dut(1, 50, 1'b1);
    check("ill_trap_cycle", trap_cyc, 2);
    check("ill_retires", ret_pc.size(), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge Clk);
      #1 if (mem_req || !trap || retire) bad++;
    end
    check("trap_hold", bad, 0);
    Rst = 1'b1;
    #1 check("trap_cleared", trap, 0);
    check("trap_rst_pc", pc_dbg, RPC);

    // Misaligned lw traps
    mem[64] = enc_i(32'h23, 1, 0, 32'h42);
    run_dut(1, 50, 1'b0);
    check("mis_trap_cycle", trap_cyc, 3);
    check("mis_trap", last_trap, 1);
    check("mis_pc", last_pc, RPC + 32'd4);

    // Reset in the middle of a stalled load
    clear_mem();
    mem[64] = enc_i(8, 5, 0, 9);
    mem[65] = enc_i(32'h23, 6, 0, 32'h40);
    stall_en = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    c = 0;
    while (!(mem_req && mem_addr == 32'h40) && c < 50) begin
      @(negedge Clk);
      c++;
    end
    check("mid_mem_reached", {mem_req, mem_addr}, {1'b1, 32'h40});
    repeat (2) @(negedge Clk);
    #2 Rst = 1'b1;
    #1 check("rst_drops_req", mem_req, 0);
    stall_en = 1'b0;
    mem[64] = enc_i(32'h2B, 5, 0, 32'h60);
    mem[65] = enc_i(32'h2B, 6, 0, 32'h64);
    exp_q.push_back({32'h60, 32'h0});
    exp_q.push_back({32'h64, 32'h0});
    run_dut(2, 100, 1'b0);
    check("refetch_addr", first_addr, RPC);
    check("rf_cleared_drain", exp_q.size(), 0);

    // Random programs against the model
    for (int t = 0; t < 12; t++) begin
      clear_mem();
      for (int i = 512; i < 576; i++) mem[i] = $urandom;
      for (int i = 0; i < 48; i++) begin
        sel = $urandom_range(0, 99);
        k   = 4 * $urandom_range(0, 63) + 32'h800;
        if (sel < 40)
          mem[64+i] = enc_r(($urandom_range(0, 39) == 0) ? 32'h21 :
                            (($urandom_range(0, 4) == 0) ? 32'h2A :
                            (($urandom_range(0, 3) == 0) ? 32'h20 :
                            (($urandom_range(0, 2) == 0) ? 32'h22 :
                            (($urandom_range(0, 1) == 0) ? 32'h24 : 32'h25)))),
                            $urandom_range(1, 7), $urandom_range(0, 7), $urandom_range(0, 7));
        else if (sel < 65)
          mem[64+i] = enc_i(8, $urandom_range(1, 7), $urandom_range(0, 7), $urandom);
        else if (sel < 75)
          mem[64+i] = enc_i(32'h23, $urandom_range(1, 7), 0,
                            k + (($urandom_range(0, 29) == 0) ? 2 : 0));
        else if (sel < 90)
          mem[64+i] = enc_i(32'h2B, $urandom_range(0, 7), 0, k);
        else if (sel < 95)
          mem[64+i] = enc_i(4, $urandom_range(0, 7), $urandom_range(0, 7),
                            $urandom_range(0, 6) - 3);
        else
          mem[64+i] = enc_j(32'h40 + $urandom_range(0, 47));
      end
      wait_f = $urandom_range(0, 2);
      wait_d = $urandom_range(0, 2);
      exp_q.delete();
      model_run(40, wait_f, wait_d, m_ret, m_trap, m_cyc, m_pc);
      run_dut(40, 800, 1'b0);
      last = (ret_cyc.size() > 0) ? ret_cyc[ret_cyc.size()-1] : -1;
      check("rnd_retires", ret_pc.size(), m_ret);
      check("rnd_trap", last_trap, m_trap);
      check("rnd_cycles", m_trap ? trap_cyc : last, m_cyc);
      check("rnd_pc", last_pc, m_pc);
      check("rnd_drain", exp_q.size(), 0);
      exp_q.delete();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
